// File: rtl/seg7_fun_pkg.sv
// Shared types and constants for the seven-segment fun front end.
// Holds the button FSM encoding, button indices and 10 MHz timing defaults.
package seg7_fun_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDebOn  = 3'd1,
    StHeld   = 3'd2,
    StRepeat = 3'd3,
    StDebOff = 3'd4
  } btn_state_e;

  localparam int unsigned BTN_INC_ANI   = 0;
  localparam int unsigned BTN_DEC_ANI   = 1;
  localparam int unsigned BTN_INC_SPEED = 2;
  localparam int unsigned BTN_DEC_SPEED = 3;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 512;
  localparam int unsigned REPEAT_DELAY_DEF    = 5_000_000;
  localparam int unsigned REPEAT_RATE_DEF     = 2_000_000;

  // Speed buttons auto-repeat, animation buttons do not.
  localparam logic [3:0] REPEAT_EN_DEF = 4'b1100;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce/repeat FSM and a shared counter.
// Level and pulse outputs are registered.
module btn_channel
  import seg7_fun_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE     = REPEAT_RATE_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_raw_i,
  input  logic repeat_en_i,
  output logic btn_level_o,
  output logic btn_press_o,
  output logic btn_release_o
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] DlyLast = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RateLast = CntW'(REPEAT_RATE - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic            s1_q, s2_q;
  btn_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= btn_raw_i;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s2_q) begin
          state_d = StDebOn;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      StDebOn: begin
        if (!s2_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StHeld;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHeld: begin
        if (!s2_q) begin
          state_d = StDebOff;
          cnt_d   = CntOne;
        end else if (!repeat_en_i) begin
          cnt_d = '0;
        end else if (cnt_q == DlyLast) begin
          state_d = StRepeat;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRepeat: begin
        if (!s2_q) begin
          state_d = StDebOff;
          cnt_d   = CntOne;
        end else if (!repeat_en_i) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q == RateLast) begin
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StDebOff: begin
        // A bounce back high returns to HELD and restarts the repeat delay.
        if (s2_q) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d   = StIdle;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign btn_level_o   = level_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end for the animation controller.
// Each channel is an independent btn_channel; no arbitration between channels.
module btn_conditioner
  import seg7_fun_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE     = REPEAT_RATE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_chan (
      .clk_i        (clk),
      .reset_i      (reset),
      .btn_raw_i    (btn_raw[i]),
      .repeat_en_i  (repeat_en[i]),
      .btn_level_o  (btn_level[i]),
      .btn_press_o  (btn_press[i]),
      .btn_release_o(btn_release[i])
    );
  end

endmodule
